// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage core.
// Resolves the hazards forwarding cannot cover (load-use, taken redirect,
// multi-cycle I/D memory, HALT drain) by driving per-stage hold, bubble and
// flush controls. It also keeps a saturating count of PC-stall cycles.
// Controls are combinational from the FSM state, the pending-redirect flag
// and the current inputs. They are forced low while reset is asserted.
module hazard_stall_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic [2:0]       RegisterRd_IDEX,
    input  logic [2:0]       RegisterRs_IFID,
    input  logic [2:0]       RegisterRt_IFID,
    input  logic             Rs_used_IFID,
    input  logic             Rt_used_IFID,
    input  logic             halt_IFID,
    input  logic             redirect_EX,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             bubble_IFID,
    output logic             stall_IDEX,
    output logic             bubble_IDEX,
    output logic             stall_EXMEM,
    output logic             bubble_MEMWB,
    output logic             halt_done,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrlState_t;

    // Drain counter only needs to reach DRAIN_CYCLES-1.
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    ctrlState_t         stateQ;
    logic [DRAIN_W-1:0] drainCnt;
    logic               redirectPend;
    logic [CNT_W-1:0]   stallCnt;

    logic loadUse;
    logic freeze;
    logic takeHalt;
    logic pendSet;
    logic pendClear;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end
        return value + CNT_W'(1);
    endfunction

    // Load in EX whose destination is read by the instruction in ID (r0 never hazards).
    always_comb begin
        loadUse = MemRead_IDEX & RegWrite_IDEX & (RegisterRd_IDEX != 3'd0) &
                  ((Rs_used_IFID & (RegisterRs_IFID == RegisterRd_IDEX)) |
                   (Rt_used_IFID & (RegisterRt_IFID == RegisterRd_IDEX)));
    end

    // A busy data memory freezes the whole pipe in every state except HALTED.
    always_comb begin
        freeze = rst & dmem_busy & (stateQ != HALTED);
    end

    // Per-stage control decode, highest-priority event first.
    always_comb begin
        stall_PC     = 1'b0;
        stall_IFID   = 1'b0;
        bubble_IFID  = 1'b0;
        stall_IDEX   = 1'b0;
        bubble_IDEX  = 1'b0;
        stall_EXMEM  = 1'b0;
        bubble_MEMWB = 1'b0;
        halt_done    = 1'b0;
        takeHalt     = 1'b0;
        pendSet      = 1'b0;
        pendClear    = 1'b0;
        if (freeze) begin
            // Hold everything up to EX/MEM and feed WB a NOP until MEM completes.
            stall_PC     = 1'b1;
            stall_IFID   = 1'b1;
            stall_IDEX   = 1'b1;
            stall_EXMEM  = 1'b1;
            bubble_MEMWB = 1'b1;
        end else if (rst) begin
            case (stateQ)
                RUN: begin
                    if (redirect_EX) begin
                        // Squash the two wrong-path instructions; PC takes the target.
                        bubble_IFID = 1'b1;
                        bubble_IDEX = 1'b1;
                    end else if (loadUse) begin
                        stall_PC    = 1'b1;
                        stall_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                    end else if (halt_IFID) begin
                        // HALT itself moves into EX; nothing behind it is fetched.
                        stall_PC   = 1'b1;
                        stall_IFID = 1'b1;
                        takeHalt   = 1'b1;
                    end else if (imem_busy) begin
                        stall_PC    = 1'b1;
                        bubble_IFID = 1'b1;
                    end
                    // A redirect during an outstanding fetch leaves a stale fetch to kill.
                    pendSet = redirect_EX & imem_busy;
                    if (redirectPend && !imem_busy) begin
                        bubble_IFID = 1'b1;
                        pendClear   = 1'b1;
                    end
                end
                DWAIT: begin
                    // Release cycle: everything idle, pending events re-examined in RUN.
                end
                DRAIN: begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    bubble_IDEX = 1'b1;
                end
                HALTED: begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    bubble_IDEX = 1'b1;
                    halt_done   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencing FSM and drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= RUN;
            drainCnt <= '0;
        end else begin
            case (stateQ)
                RUN: begin
                    if (dmem_busy) begin
                        stateQ <= DWAIT;
                    end else if (takeHalt) begin
                        stateQ   <= DRAIN;
                        drainCnt <= '0;
                    end
                end
                DWAIT: begin
                    if (!dmem_busy) begin
                        stateQ <= RUN;
                    end
                end
                DRAIN: begin
                    // The drain clock pauses while MEM is frozen.
                    if (!dmem_busy) begin
                        if (drainCnt == DRAIN_LAST) begin
                            stateQ <= HALTED;
                        end else begin
                            drainCnt <= drainCnt + DRAIN_W'(1);
                        end
                    end
                end
                HALTED: begin
                    stateQ <= HALTED;
                end
                default: begin
                    stateQ <= RUN;
                end
            endcase
        end
    end

    // Pending-redirect flag; a new set takes precedence over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirectPend <= 1'b0;
        end else if (pendSet) begin
            redirectPend <= 1'b1;
        end else if (pendClear) begin
            redirectPend <= 1'b0;
        end
    end

    // Stall-cycle performance counter, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (stall_PC) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    assign ctrl_state   = stateQ;
    assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 16;

    // Control bundle order: PC, IFID stall, IFID bubble, IDEX stall, IDEX bubble,
    // EXMEM stall, MEMWB bubble, halt_done.
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_FREEZE = 8'b1101_0110;
    localparam logic [7:0] C_REDIR  = 8'b0010_1000;
    localparam logic [7:0] C_LU     = 8'b1100_1000;
    localparam logic [7:0] C_HALT   = 8'b1100_0000;
    localparam logic [7:0] C_IMEM   = 8'b1010_0000;
    localparam logic [7:0] C_DRAIN  = 8'b1100_1000;
    localparam logic [7:0] C_HALTED = 8'b1100_1001;
    localparam logic [7:0] C_SQUASH = 8'b0010_0000;

    logic clk = 1'b0;
    logic rst;
    logic MemRead_IDEX, RegWrite_IDEX;
    logic [2:0] RegisterRd_IDEX, RegisterRs_IFID, RegisterRt_IFID;
    logic Rs_used_IFID, Rt_used_IFID, halt_IFID, redirect_EX, imem_busy, dmem_busy;
    logic stall_PC, stall_IFID, bubble_IFID, stall_IDEX, bubble_IDEX;
    logic stall_EXMEM, bubble_MEMWB, halt_done;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
        .RegisterRd_IDEX(RegisterRd_IDEX), .RegisterRs_IFID(RegisterRs_IFID),
        .RegisterRt_IFID(RegisterRt_IFID), .Rs_used_IFID(Rs_used_IFID),
        .Rt_used_IFID(Rt_used_IFID), .halt_IFID(halt_IFID),
        .redirect_EX(redirect_EX), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .bubble_IFID(bubble_IFID),
        .stall_IDEX(stall_IDEX), .bubble_IDEX(bubble_IDEX),
        .stall_EXMEM(stall_EXMEM), .bubble_MEMWB(bubble_MEMWB),
        .halt_done(halt_done), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dutCtrl();
        return {stall_PC, stall_IFID, bubble_IFID, stall_IDEX, bubble_IDEX,
                stall_EXMEM, bubble_MEMWB, halt_done};
    endfunction

    task automatic idle();
        MemRead_IDEX = 0; RegWrite_IDEX = 0; RegisterRd_IDEX = 0;
        RegisterRs_IFID = 0; RegisterRt_IFID = 0; Rs_used_IFID = 0; Rt_used_IFID = 0;
        halt_IFID = 0; redirect_EX = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLoadUse(input logic [2:0] rd, input logic [2:0] rs);
        MemRead_IDEX = 1; RegWrite_IDEX = 1; RegisterRd_IDEX = rd;
        RegisterRs_IFID = rs; Rs_used_IFID = 1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Mode: 0 running, 1 waiting on dmem release, 2 draining, 3 halted.
    int mMode, mDrainLeft, mCnt, nMode, nDrainLeft;
    bit mPend, nPend;
    logic [7:0] expC;

    task automatic modelReset();
        mMode = 0; mDrainLeft = 0; mPend = 0; mCnt = 0;
    endtask

    task automatic modelEval();
        bit lu;
        nMode = mMode; nDrainLeft = mDrainLeft; nPend = mPend; expC = C_NONE;
        lu = MemRead_IDEX && RegWrite_IDEX && RegisterRd_IDEX != 0 &&
             ((Rs_used_IFID && RegisterRs_IFID == RegisterRd_IDEX) ||
              (Rt_used_IFID && RegisterRt_IFID == RegisterRd_IDEX));
        if (!rst) begin
            expC = C_NONE;
        end else if (mMode == 3) begin
            expC = C_HALTED;
        end else if (dmem_busy) begin
            expC = C_FREEZE;
            if (mMode == 0) nMode = 1;
        end else if (mMode == 1) begin
            nMode = 0;
        end else if (mMode == 2) begin
            expC = C_DRAIN;
            nDrainLeft = mDrainLeft - 1;
            if (nDrainLeft == 0) nMode = 3;
        end else begin
            if (redirect_EX) expC = C_REDIR;
            else if (lu) expC = C_LU;
            else if (halt_IFID) begin expC = C_HALT; nMode = 2; nDrainLeft = DRAIN_CYCLES; end
            else if (imem_busy) expC = C_IMEM;
            if (mPend && !imem_busy) begin expC[5] = 1'b1; nPend = 0; end
            if (redirect_EX && imem_busy) nPend = 1;
        end
    endtask

    task automatic modelClock();
        if (rst) begin
            if (expC[7] && mCnt < 65535) mCnt = mCnt + 1;
            mMode = nMode; mDrainLeft = nDrainLeft; mPend = nPend;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 0; dmem_busy = 1; halt_IFID = 1; redirect_EX = 1; imem_busy = 1;
        #3;
        total++;
        if ({dutCtrl(), ctrl_state, stall_cycles} !== 26'd0) begin
            bad++; $display("FAIL reset_outputs got %h want 0", {dutCtrl(), ctrl_state, stall_cycles});
        end
        tick();
        total++;
        if ({dutCtrl(), ctrl_state, stall_cycles} !== 26'd0) begin
            bad++; $display("FAIL reset_held got %h want 0", {dutCtrl(), ctrl_state, stall_cycles});
        end
        rst = 1; idle();
        @(negedge clk);
        total++;
        if ({dutCtrl(), ctrl_state, stall_cycles} !== 26'd0) begin
            bad++; $display("FAIL reset_release got %h want 0", {dutCtrl(), ctrl_state, stall_cycles});
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] cnt0;
        idle();
        cnt0 = stall_cycles;
        setLoadUse(3'd3, 3'd3);
        @(negedge clk); total++;
        if (dutCtrl() !== C_LU) begin bad++; $display("FAIL lu_stall got %b want %b", dutCtrl(), C_LU); end
        tick();
        MemRead_IDEX = 0; RegWrite_IDEX = 0;
        @(negedge clk); total++;
        if (dutCtrl() !== C_NONE || stall_cycles !== cnt0 + 16'd1) begin
            bad++; $display("FAIL lu_release got %b/%0d want %b/%0d", dutCtrl(), stall_cycles, C_NONE, cnt0 + 16'd1);
        end
        tick();
        setLoadUse(3'd0, 3'd0);
        @(negedge clk); total++;
        if (dutCtrl() !== C_NONE) begin bad++; $display("FAIL lu_rd_zero got %b want %b", dutCtrl(), C_NONE); end
        tick();
        setLoadUse(3'd5, 3'd1); RegisterRt_IFID = 3'd5; Rt_used_IFID = 1;
        @(negedge clk); total++;
        if (dutCtrl() !== C_LU) begin bad++; $display("FAIL lu_rt got %b want %b", dutCtrl(), C_LU); end
        tick();
        Rt_used_IFID = 0; MemRead_IDEX = 0;
        @(negedge clk); total++;
        if (dutCtrl() !== C_NONE) begin bad++; $display("FAIL lu_not_load got %b want %b", dutCtrl(), C_NONE); end
        tick();
        idle();
    endtask

    task automatic test_dmem_freeze();
        logic [CNT_W-1:0] cnt0;
        logic dm [0:4];
        logic rd [0:4];
        logic [7:0] ec [0:4];
        logic [1:0] es [0:4];
        dm = '{1, 1, 1, 0, 0};
        rd = '{1, 1, 1, 1, 0};
        ec = '{C_FREEZE, C_FREEZE, C_FREEZE, C_NONE, C_LU};
        es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        idle();
        cnt0 = stall_cycles;
        setLoadUse(3'd2, 3'd2);
        for (int i = 0; i < 5; i++) begin
            dmem_busy = dm[i]; redirect_EX = rd[i];
            @(negedge clk); total++;
            if ({dutCtrl(), ctrl_state} !== {ec[i], es[i]}) begin
                bad++; $display("FAIL dmem_cycle%0d got %b/%0d want %b/%0d", i, dutCtrl(), ctrl_state, ec[i], es[i]);
            end
            tick();
        end
        idle();
        @(negedge clk); total++;
        if (stall_cycles !== cnt0 + 16'd4 || ctrl_state !== 2'd0) begin
            bad++; $display("FAIL dmem_stall_count got %0d/%0d want %0d/0", stall_cycles, ctrl_state, cnt0 + 16'd4);
        end
        tick();
    endtask

    task automatic test_redirect_pend();
        logic rd [0:3];
        logic im [0:3];
        logic [7:0] ec [0:3];
        rd = '{1, 0, 0, 0};
        im = '{1, 1, 0, 0};
        ec = '{C_REDIR, C_IMEM, C_SQUASH, C_NONE};
        idle();
        for (int i = 0; i < 4; i++) begin
            redirect_EX = rd[i]; imem_busy = im[i];
            @(negedge clk); total++;
            if (dutCtrl() !== ec[i]) begin
                bad++; $display("FAIL redirect_cycle%0d got %b want %b", i, dutCtrl(), ec[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_halt_drain();
        logic dm [0:9];
        logic [7:0] ec [0:9];
        logic [1:0] es [0:9];
        dm = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
        ec = '{C_HALT, C_DRAIN, C_FREEZE, C_FREEZE, C_DRAIN, C_DRAIN, C_DRAIN,
               C_HALTED, C_HALTED, C_HALTED};
        es = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
        idle();
        for (int i = 0; i < 10; i++) begin
            halt_IFID = (i == 0); dmem_busy = dm[i];
            @(negedge clk); total++;
            if ({dutCtrl(), ctrl_state} !== {ec[i], es[i]}) begin
                bad++; $display("FAIL halt_cycle%0d got %b/%0d want %b/%0d", i, dutCtrl(), ctrl_state, ec[i], es[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        halt_IFID = 1;
        tick();
        halt_IFID = 0;
        tick();
        #2;
        rst = 0; dmem_busy = 1;
        #1; total++;
        if ({dutCtrl(), ctrl_state, stall_cycles} !== 26'd0) begin
            bad++; $display("FAIL async_reset got %h want 0", {dutCtrl(), ctrl_state, stall_cycles});
        end
        tick();
        rst = 1; idle();
        setLoadUse(3'd4, 3'd4);
        @(negedge clk); total++;
        if ({dutCtrl(), ctrl_state} !== {C_LU, 2'd0}) begin
            bad++; $display("FAIL resume_after_reset got %b/%0d want %b/0", dutCtrl(), ctrl_state, C_LU);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        idle();
        rst = 0; #1; rst = 1;
        imem_busy = 1;
        repeat (65534) @(posedge clk);
        #1; total++;
        if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL sat_below got %h want fffe", stall_cycles); end
        tick(); total++;
        if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got %h want ffff", stall_cycles); end
        repeat (5) tick();
        total++;
        if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got %h want ffff", stall_cycles); end
        idle();
    endtask

    task automatic test_random();
        int haltedFor;
        int errs;
        errs = 0;
        haltedFor = 0;
        idle();
        rst = 0; #1; rst = 1;
        modelReset();
        for (int n = 0; n < 2000; n++) begin
            rst = !((haltedFor > 3) || ($urandom_range(0, 199) == 0));
            if (!rst) modelReset();
            MemRead_IDEX    = ($urandom_range(0, 2) == 0);
            RegWrite_IDEX   = ($urandom_range(0, 3) != 0);
            RegisterRd_IDEX = 3'($urandom_range(0, 3));
            RegisterRs_IFID = 3'($urandom_range(0, 3));
            RegisterRt_IFID = 3'($urandom_range(0, 3));
            Rs_used_IFID    = $urandom_range(0, 1);
            Rt_used_IFID    = $urandom_range(0, 1);
            halt_IFID       = ($urandom_range(0, 39) == 0);
            redirect_EX     = ($urandom_range(0, 6) == 0);
            imem_busy       = ($urandom_range(0, 3) == 0);
            dmem_busy       = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            modelEval();
            total++;
            if ({dutCtrl(), ctrl_state, stall_cycles} !== {expC, 2'(mMode), 16'(mCnt)}) begin
                bad++;
                if (errs < 10) $display("FAIL random_cycle%0d got %b/%0d/%0d want %b/%0d/%0d", n,
                                        dutCtrl(), ctrl_state, stall_cycles, expC, mMode, mCnt);
                errs++;
            end
            @(posedge clk);
            modelClock();
            haltedFor = (mMode == 3) ? haltedFor + 1 : 0;
            #1;
        end
        rst = 1;
        idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_dmem_freeze();
        test_redirect_pend();
        test_halt_drain();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
